// File: rtl/multicycle_ctrl_fsm.sv
// Hardwired IF/ID/EX/MEM/WB control sequencer for the multi-cycle RV32I datapath.
// Strobes and selects decode combinationally from state/opcode; traps latch sticky error flags.
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       ecall_halt,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ctrl_sel,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       is_halted,
    output logic       err_illegal,
    output logic       err_timeout,
    output logic [2:0] state
);

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    state_t        cur;
    logic [CW-1:0] wait_cnt;
    logic          is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_ecall;
    logic          is_exec, timed_out;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_ld     = (opcode == OP_LOAD);
    assign is_st     = (opcode == OP_STORE);
    assign is_br     = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_ecall  = (opcode == OP_ECALL);
    assign is_exec   = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr;
    assign timed_out = (wait_cnt == CNT_LAST);
    assign state     = cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= S_IF;
            wait_cnt    <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (cur)
                S_IF: begin
                    // mem_ready wins over a timeout landing in the same cycle
                    if (mem_ready) begin
                        cur      <= S_ID;
                        wait_cnt <= '0;
                    end else if (timed_out) begin
                        cur         <= S_HALT;
                        wait_cnt    <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_ID: begin
                    if (is_ecall) begin
                        cur <= ecall_halt ? S_HALT : S_IF;
                    end else if (is_exec) begin
                        cur <= S_EX;
                    end else begin
                        cur         <= S_HALT;
                        err_illegal <= 1'b1;
                    end
                end
                S_EX: begin
                    if (is_ld || is_st) begin
                        cur <= S_MEM;
                    end else if (is_br) begin
                        cur <= S_IF;
                    end else if (is_r || is_i || is_jal || is_jalr) begin
                        cur <= S_WB;
                    end else begin
                        cur         <= S_HALT;
                        err_illegal <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        cur      <= is_ld ? S_WB : S_IF;
                        wait_cnt <= '0;
                    end else if (timed_out) begin
                        cur         <= S_HALT;
                        wait_cnt    <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_WB:    cur <= S_IF;
                S_HALT:  cur <= S_HALT;
                default: cur <= S_IF;
            endcase
        end
    end

    always_comb begin
        ir_write     = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_ctrl_sel = 2'b00;
        pc_write     = 1'b0;
        pc_source    = 2'b00;
        is_halted    = 1'b0;
        case (cur)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_ID: begin
                pc_write = is_ecall & ~ecall_halt;
            end
            S_EX: begin
                if (is_r) begin
                    alu_src_a    = 1'b1;
                    alu_ctrl_sel = 2'b01;
                end else if (is_i) begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = 2'b10;
                    alu_ctrl_sel = 2'b01;
                end else if (is_ld || is_st || is_jalr) begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = 2'b10;
                end else if (is_br) begin
                    alu_src_a    = 1'b1;
                    alu_ctrl_sel = 2'b10;
                    pc_write     = 1'b1;
                    pc_source    = alu_bcond ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = is_ld;
                mem_write = is_st;
                pc_write  = is_st & mem_ready;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (is_ld) begin
                    wb_sel = 2'b01;
                end else if (is_jal) begin
                    wb_sel    = 2'b10;
                    pc_source = 2'b01;
                end else if (is_jalr) begin
                    wb_sel    = 2'b10;
                    pc_source = 2'b10;
                end
            end
            S_HALT:  is_halted = 1'b1;
            default: ;
        endcase
        // state resets asynchronously to IF, so the fetch request must be masked here too
        if (!reset) begin
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Hardwired control FSM that sequences the team's multi-cycle RV32I datapath through IF/ID/EX/MEM/WB over a shared unified memory.
- The datapath contains the PC, IR, MDR, A/B, ALUOut registers, the single ALU and the register file.
- This block drives every register-enable and mux-select in that datapath.
- It handles memory wait states via a ready handshake, branch resolution, JAL/JALR link, ECALL halt, and illegal-opcode and memory-timeout traps.

Parameters:
- MEM_TIMEOUT, 16: max cycles a memory access may wait for mem_ready before trapping; must be ≥2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  IR[6:0], valid from ID onward.
- alu_bcond  input  1  branch-condition result from ALU, valid in EX.
- ecall_halt  input  1  high when x17==10; sampled in ID for ECALL.
- mem_ready  input  1  memory completes the current access this cycle.
- ir_write  output  1  load IR from memory dout.
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request, data=B.
- reg_write  output  1  register-file write of rd.
- wb_sel  output  2  rd data: 00=ALUOut, 01=MDR, 10=PC+4.
- alu_src_a  output  1  0=PC, 1=A.
- alu_src_b  output  2  00=B, 01=const 4, 10=imm.
- alu_ctrl_sel  output  2  00=force ADD, 01=funct-decoded, 10=branch compare.
- pc_write  output  1  update PC this cycle.
- pc_source  output  2  00=PC+4, 01=PC+imm, 10=ALUOut (JALR target, LSB cleared by datapath).
- is_halted  output  1  FSM in HALT.
- err_illegal  output  1  sticky: unknown opcode trapped.
- err_timeout  output  1  sticky: memory timeout trapped.
- state  output  3  debug: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.

Behaviour:
- Reset low → state=IF, timeout counter=0, err flags=0.
- While reset is low, all strobes (ir_write, mem_read, mem_write, reg_write, pc_write) are forced 0.
- The first fetch request is issued in the first cycle after deassertion.
- Selects and strobes are combinational from state and opcode. ir_write and pc_write additionally depend on mem_ready and alu_bcond.
- Unlisted outputs in any state are 0.
- IF:
  - i_or_d=0, mem_read=1, ir_write=mem_ready.
  - mem_ready → ID, counter cleared.
  - Otherwise counter++; when counter==MEM_TIMEOUT-1 without ready → HALT, err_timeout=1.
- ID:
  - Datapath latches A/B.
  - ECALL (1110011): if ecall_halt → HALT. Else pc_write=1, pc_source=00 → IF.
  - Opcodes R(0110011), I(0010011), LOAD(0000011), STORE(0100011), BRANCH(1100011), JAL(1101111), JALR(1100111) → EX.
  - Any other opcode → HALT, err_illegal=1.
- EX:
  - R: alu_src_a=1, alu_src_b=00, alu_ctrl_sel=01 → WB.
  - I: alu_src_a=1, alu_src_b=10, alu_ctrl_sel=01 → WB.
  - LOAD/STORE: alu_src_a=1, alu_src_b=10, alu_ctrl_sel=00 → MEM.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl_sel=10, pc_write=1, pc_source = alu_bcond ? 01 : 00 → IF.
  - JAL: no ALU use → WB.
  - JALR: alu_src_a=1, alu_src_b=10, alu_ctrl_sel=00 → WB.
- MEM:
  - i_or_d=1; mem_read=1 for LOAD, mem_write=1 for STORE.
  - The request is held unchanged until mem_ready, using the same timeout rule as IF.
  - On ready: LOAD → WB; STORE asserts pc_write=1, pc_source=00 → IF.
- WB:
  - reg_write=1, pc_write=1 → IF.
  - R/I: wb_sel=00, pc_source=00.
  - LOAD: wb_sel=01, pc_source=00.
  - JAL: wb_sel=10, pc_source=01.
  - JALR: wb_sel=10, pc_source=10.
- HALT:
  - Absorbing; is_halted=1; all strobes 0; exits only via reset.
- Timeout counter:
  - Counts only in IF/MEM while waiting.
  - Cleared on every state change.
  - Width ceil(log2(MEM_TIMEOUT)).
  - mem_ready in the same cycle the count hits MEM_TIMEOUT-1 counts as success (ready wins).
- Reset asserted mid-access:
  - The outstanding request is dropped immediately (strobes 0).
  - No PC, register or memory write occurs.
- Cycle counts with zero-wait memory:
  - R/I: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - JAL/JALR: 4 cycles.
  - ECALL: 2 cycles.

Test Plan:
1. Release reset, mem_ready=1, opcode=0110011 → state 0,1,2,4,0; reg_write=1, wb_sel=00 in WB; pc_write=1 exactly once per instruction.
2. LOAD, mem_ready low for 3 cycles in MEM → mem_read=1, i_or_d=1 held 4 cycles; then WB with wb_sel=01; total 8 cycles.
3. BRANCH with alu_bcond=1, then alu_bcond=0 → EX pc_write=1 with pc_source=01, then 00; back to IF after 3 cycles each; reg_write never 1.
4. JALR → EX alu_src_b=10, alu_ctrl_sel=00; WB reg_write=1, wb_sel=10, pc_source=10.
5. ECALL with ecall_halt=1 → HALT in 2 cycles; is_halted=1, state=7; stays halted 20 cycles despite any input. With ecall_halt=0 → PC+4, back to IF.
6. mem_ready held 0 in IF, MEM_TIMEOUT=16 → after 16 cycles HALT, err_timeout=1. Separately: opcode=0000000 → HALT with err_illegal=1. Assert reset during MEM → strobes 0 immediately; state=0, flags cleared.
